// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one byte-wide I2C master between two requesters.
// Sequences issue, start-wait and completion, and recovers from a silent or
// stuck master by pulsing i2c_rst before reporting an error completion.
module i2c_txn_arbiter #(
    parameter int unsigned START_TIMEOUT = 255,
    parameter int unsigned XFER_TIMEOUT  = 65535,
    parameter int unsigned RST_CYCLES    = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_rw,
    input  logic [7:0] req0_dev_addr,
    input  logic [7:0] req0_reg_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    output logic       req0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_rw,
    input  logic [7:0] req1_dev_addr,
    input  logic [7:0] req1_reg_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       req1_err,
    output logic       grant_id,
    output logic       i2c_en,
    output logic       i2c_rw,
    output logic [7:0] i2c_dev_addr,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_mosi,
    output logic       i2c_rst,
    input  logic       i2c_busy,
    input  logic [7:0] i2c_miso
);

    localparam int unsigned MAX_AB = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned MAX_T  = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] START_LIM = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] XFER_LIM  = CW'(XFER_TIMEOUT);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COMPLETE,
        S_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          last_q, last_d;
    logic          grant_q, grant_d;
    logic          rw_q, rw_d;
    logic [7:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    mosi_q, mosi_d;
    logic          fault_q, fault_d;
    logic [7:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic          win1, ready0, ready1;
    logic [7:0]    cpl_rdata;

    // State register and datapath latches
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            mosi_q   <= '0;
            fault_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            rw_q     <= rw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            mosi_q   <= mosi_d;
            fault_q  <= fault_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    // Next-state, arbitration and strobe generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        mosi_d   = mosi_q;
        fault_d  = fault_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        ready0   = 1'b0;
        ready1   = 1'b0;
        i2c_en   = 1'b0;
        i2c_rst  = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        win1      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        cpl_rdata = (fault_q || !rw_q) ? 8'h00 : i2c_miso;

        case (state_q)
            S_IDLE: begin
                if (!i2c_busy && (req0_valid || req1_valid)) begin
                    ready0  = ~win1;
                    ready1  = win1;
                    grant_d = win1;
                    last_d  = win1;
                    rw_d    = win1 ? req1_rw : req0_rw;
                    dev_d   = win1 ? req1_dev_addr : req0_dev_addr;
                    reg_d   = win1 ? req1_reg_addr : req0_reg_addr;
                    mosi_d  = (win1 ? req1_rw : req0_rw) ? 8'h00
                                                         : (win1 ? req1_wdata : req0_wdata);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                i2c_en  = 1'b1;
                cnt_d   = '0;
                fault_d = 1'b0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i2c_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= START_LIM) begin
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!i2c_busy) begin
                    state_d = S_COMPLETE;
                end else if (cnt_q >= XFER_LIM) begin
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RECOVER: begin
                i2c_rst = 1'b1;
                if (cnt_q >= RST_LAST) begin
                    state_d = S_COMPLETE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_COMPLETE: begin
                // The error completion after recovery shares this state; fault_q selects err=1, rdata=0.
                if (grant_q) begin
                    rdata1_d = cpl_rdata;
                    err1_d   = fault_q;
                end else begin
                    rdata0_d = cpl_rdata;
                    err0_d   = fault_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Requester-facing outputs; completion values are live during the done cycle, then held
    always_comb begin
        req0_ready   = ready0 & reset_reset_n;
        req1_ready   = ready1 & reset_reset_n;
        req0_done    = (state_q == S_COMPLETE) && !grant_q;
        req1_done    = (state_q == S_COMPLETE) && grant_q;
        req0_rdata   = req0_done ? cpl_rdata : rdata0_q;
        req1_rdata   = req1_done ? cpl_rdata : rdata1_q;
        req0_err     = req0_done ? fault_q : err0_q;
        req1_err     = req1_done ? fault_q : err1_q;
        grant_id     = grant_q;
        i2c_rw       = rw_q;
        i2c_dev_addr = dev_q;
        i2c_reg_addr = reg_q;
        i2c_mosi     = mosi_q;
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a behavioural I2C master model.
module tb_i2c_txn_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_ready, req0_rw = 1'b0;
    logic [7:0] req0_dev_addr = '0, req0_reg_addr = '0, req0_wdata = '0;
    logic       req0_done, req0_err;
    logic [7:0] req0_rdata;
    logic       req1_valid = 1'b0, req1_ready, req1_rw = 1'b0;
    logic [7:0] req1_dev_addr = '0, req1_reg_addr = '0, req1_wdata = '0;
    logic       req1_done, req1_err;
    logic [7:0] req1_rdata;
    logic       grant_id, i2c_en, i2c_rw, i2c_rst;
    logic [7:0] i2c_dev_addr, i2c_reg_addr, i2c_mosi;
    logic       i2c_busy = 1'b0;
    logic [7:0] i2c_miso = '0;

    // Master model controls: mode 0 answers en, mode 1 ignores en; mm_force is the idle busy level
    int         mm_mode  = 0;
    int         mm_len   = 4;
    logic       mm_force = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(
        .START_TIMEOUT(8),
        .XFER_TIMEOUT (32),
        .RST_CYCLES   (16)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_rw      (req0_rw),
        .req0_dev_addr(req0_dev_addr),
        .req0_reg_addr(req0_reg_addr),
        .req0_wdata   (req0_wdata),
        .req0_done    (req0_done),
        .req0_rdata   (req0_rdata),
        .req0_err     (req0_err),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_rw      (req1_rw),
        .req1_dev_addr(req1_dev_addr),
        .req1_reg_addr(req1_reg_addr),
        .req1_wdata   (req1_wdata),
        .req1_done    (req1_done),
        .req1_rdata   (req1_rdata),
        .req1_err     (req1_err),
        .grant_id     (grant_id),
        .i2c_en       (i2c_en),
        .i2c_rw       (i2c_rw),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_mosi     (i2c_mosi),
        .i2c_rst      (i2c_rst),
        .i2c_busy     (i2c_busy),
        .i2c_miso     (i2c_miso)
    );

    // Ideal master: busy rises one cycle after en and stays high mm_len cycles
    initial begin
        forever begin
            @(negedge clk);
            if (mm_mode == 0 && i2c_en === 1'b1) begin
                @(negedge clk);
                i2c_busy = 1'b1;
                repeat (mm_len) @(negedge clk);
                i2c_busy = 1'b0;
            end else begin
                i2c_busy = mm_force;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic v, input logic rw, input logic [7:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        if (id) begin
            req1_valid = v; req1_rw = rw; req1_dev_addr = dev; req1_reg_addr = rg; req1_wdata = wd;
        end else begin
            req0_valid = v; req0_rw = rw; req0_dev_addr = dev; req0_reg_addr = rg; req0_wdata = wd;
        end
    endtask

    // Raises valid and waits (bounded) for the accept strobe; returns at the accept cycle + #1
    task automatic wait_ready(input bit id, input string name);
        int n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk(name, {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
    endtask

    // Waits (bounded) for rst to rise then counts its length; checks the error completion after it
    task automatic check_recovery(input bit id, input int lo, input int hi, input string name);
        int n = 0;
        int m = 0;
        while (!i2c_rst && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk({name, "_rst_delay"}, {31'd0, (n >= lo && n <= hi)}, 32'd1);
        while (i2c_rst && m < 100) begin
            @(negedge clk); #1; m++;
        end
        chk({name, "_rst_len"}, m, 32'd16);
        chk({name, "_done"}, {31'd0, (id ? req1_done : req0_done)}, 32'd1);
        chk({name, "_err"}, {31'd0, (id ? req1_err : req0_err)}, 32'd1);
        chk({name, "_rdata"}, {24'd0, (id ? req1_rdata : req0_rdata)}, 32'd0);
    endtask

    task automatic run_txn(input bit id, input logic rw, input logic [7:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] miso, input int len,
                           input logic [7:0] exp_rd);
        logic [7:0] o_rd;
        logic       o_err;
        bit         o_done = 0;
        bit         seen_busy = 0;
        int         n = 0;
        @(negedge clk);
        mm_mode = 0; mm_len = len; i2c_miso = miso;
        o_rd  = id ? req0_rdata : req1_rdata;
        o_err = id ? req0_err : req1_err;
        set_req(id, 1'b1, rw, dev, rg, wd);
        wait_ready(id, "txn_ready");
        @(negedge clk);
        set_req(id, 1'b0, rw, dev, rg, wd);
        #1;
        chk("txn_en", {31'd0, i2c_en}, 32'd1);
        chk("txn_ready_pulse", {31'd0, (id ? req1_ready : req0_ready)}, 32'd0);
        chk("txn_grant", {31'd0, grant_id}, {31'd0, id});
        chk("txn_dev", {24'd0, i2c_dev_addr}, {24'd0, dev});
        chk("txn_reg", {24'd0, i2c_reg_addr}, {24'd0, rg});
        while (!(id ? req1_done : req0_done) && n < len + 50) begin
            @(negedge clk); #1; n++;
            if (id ? req0_done : req1_done) o_done = 1;
            if (i2c_busy && !seen_busy) begin
                seen_busy = 1;
                chk("txn_busy_rw", {31'd0, i2c_rw}, {31'd0, rw});
                chk("txn_busy_mosi", {24'd0, i2c_mosi}, {24'd0, (rw ? 8'h00 : wd)});
            end
        end
        chk("txn_done_latency", n, len + 2);
        chk("txn_rdata", {24'd0, (id ? req1_rdata : req0_rdata)}, {24'd0, exp_rd});
        chk("txn_err", {31'd0, (id ? req1_err : req0_err)}, 32'd0);
        chk("txn_other_quiet", {23'd0, o_done, (id ? req0_rdata : req1_rdata)}, {24'd0, o_rd});
        chk("txn_other_err", {31'd0, (id ? req0_err : req1_err)}, {31'd0, o_err});
        @(negedge clk); #1;
        chk("txn_done_pulse", {31'd0, (id ? req1_done : req0_done)}, 32'd0);
        chk("txn_rdata_held", {24'd0, (id ? req1_rdata : req0_rdata)}, {24'd0, exp_rd});
    endtask

    typedef struct {
        bit         id;
        logic       rw;
        logic [7:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] miso;
        int         len;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  n;
        int  exp_g;
        bit  bad;

        vecs[0] = '{1'b0, 1'b1, 8'h53, 8'h32, 8'h00, 8'hA5, 20, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h10, 8'h08, 8'h5A,  5, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 8'h7F, 8'hFF, 8'hFF, 8'hEE,  1, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h44, 8'h3C,  3, 8'h3C};
        vecs[4] = '{1'b1, 1'b1, 8'h02, 8'h81, 8'h00, 8'hC3,  2, 8'hC3};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err,
                            grant_id, i2c_en, i2c_rw, i2c_rst}, 32'd0);
        chk("rst_buses", {req0_rdata, req1_rdata, i2c_dev_addr, i2c_reg_addr}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_idle", {req0_ready, req1_ready, i2c_en, i2c_rst, i2c_mosi}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].id, vecs[i].rw, vecs[i].dev, vecs[i].rg, vecs[i].wd,
                    vecs[i].miso, vecs[i].len, vecs[i].exp_rd);
        end

        // Simultaneous requests after reset, held valid: grants alternate 0,1,0,1
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mm_mode = 0; mm_len = 4; i2c_miso = 8'h77;
        set_req(1'b0, 1'b1, 1'b1, 8'hA0, 8'h01, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'hB1, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 100) begin
                @(negedge clk); #1; n++;
            end
            chk("alt_ready", {30'd0, req1_ready, req0_ready}, (exp_g == 1) ? 32'd2 : 32'd1);
            @(negedge clk); #1;
            chk("alt_grant", {31'd0, grant_id}, exp_g);
            chk("alt_dev", {24'd0, i2c_dev_addr}, (exp_g == 1) ? 32'hB1 : 32'hA0);
            n = 0;
            while (!(exp_g == 1 ? req1_done : req0_done) && n < 100) begin
                @(negedge clk); #1; n++;
            end
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            chk("alt_done", {31'd0, (exp_g == 1 ? req1_done : req0_done)}, 32'd1);
            @(negedge clk);
        end

        // Start timeout: master never raises busy
        mm_mode = 1;
        set_req(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 8'h00);
        wait_ready(1'b0, "sto_ready");
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("sto_en", {31'd0, i2c_en}, 32'd1);
        check_recovery(1'b0, 8, 12, "sto");
        mm_mode = 0;
        run_txn(1'b0, 1'b1, 8'h12, 8'h34, 8'h00, 8'h99, 6, 8'h99);

        // Stuck busy beyond the transfer timeout
        @(negedge clk);
        mm_mode = 1;
        set_req(1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 8'h00);
        wait_ready(1'b1, "stk_ready");
        @(negedge clk);
        req1_valid = 1'b0;
        mm_force = 1'b1;
        #1;
        chk("stk_en", {31'd0, i2c_en}, 32'd1);
        n = 0;
        while (!i2c_busy && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check_recovery(1'b1, 32, 36, "stk");
        chk("stk_req0_untouched", {23'd0, req0_err, req0_rdata}, 32'h099);
        mm_force = 1'b0; mm_mode = 0;
        repeat (2) @(negedge clk);

        // Busy high in IDLE blocks the grant until it falls
        mm_force = 1'b1;
        repeat (2) @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h55, 8'h66, 8'h3D);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req0_ready) bad = 1;
            @(negedge clk);
        end
        chk("busy_idle_no_ready", {31'd0, bad}, 32'd0);
        mm_force = 1'b0;
        n = 0;
        #1;
        while (!req0_ready && n < 6) begin
            @(negedge clk); #1; n++;
        end
        chk("busy_idle_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        n = 0;
        #1;
        while (!req0_done && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("busy_idle_done", {30'd0, req0_done, req0_err}, 32'd2);

        // Reset while in WAIT_DONE
        @(negedge clk);
        mm_mode = 0; mm_len = 30;
        set_req(1'b0, 1'b1, 1'b1, 8'h70, 8'h71, 8'h00);
        wait_ready(1'b0, "mid_ready");
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_outputs", {req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err,
                            grant_id, i2c_en, i2c_rw, i2c_rst}, 32'd0);
        chk("mid_buses", {req0_rdata, req1_rdata, i2c_dev_addr, i2c_reg_addr}, 32'd0);
        chk("mid_mosi", {24'd0, i2c_mosi}, 32'd0);
        bad = 0;
        n = 0;
        while (i2c_busy && n < 60) begin
            if (req0_done || req1_done || i2c_rst || i2c_en) bad = 1;
            @(negedge clk); #1; n++;
        end
        chk("mid_no_pulses", {31'd0, bad}, 32'd0);
        set_req(1'b0, 1'b1, 1'b1, 8'h0A, 8'h0B, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'h1A, 8'h1B, 8'h00);
        mm_len = 3;
        #1;
        chk("mid_fresh_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        #1;
        while (!req0_done && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("mid_fresh_done", {31'd0, req0_done}, 32'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
